// File: rtl/int_sequencer.sv
// int_sequencer: arbitrates reset, edge NMI, masked level IRQ channels and BRK at
// instruction boundaries, and drives the control FSM's interrupt sequence.
module int_sequencer #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic               phi1,
    input  logic               rst,
    input  logic               rst_req,
    input  logic               nmi_n,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               i_flag,
    input  logic               brk_op,
    input  logic               boundary,
    input  logic               done,
    output logic               take,
    output logic [1:0]         int_type,
    output logic [15:0]        vector,
    output logic [ID_W-1:0]    irq_id,
    output logic               b_flag,
    output logic               rst_handled,
    output logic               nmi_handled,
    output logic               irq_handled,
    output logic               busy
);
    typedef enum logic [1:0] {RSTSEQ, IDLE, ACTIVE} stateT;

    stateT               state, stateN;
    logic                nmiPrev, nmiPend, nmiAccept;
    logic [NUM_IRQ-1:0]  irqReq;
    logic [ID_W-1:0]     irqSel, idN;
    logic                takeN, bN, rstHN, nmiHN, irqHN;
    logic [1:0]          typeN;
    logic [15:0]         vectorN;

    assign irqReq = ~irq_n & irq_en & {NUM_IRQ{~i_flag}};
    assign busy   = take;

    // Scan downward so the lowest requesting channel is the last to win.
    always_comb begin
        irqSel = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (irqReq[k]) irqSel = ID_W'(k);
    end

    always_comb begin
        stateN    = state;
        takeN     = take;
        typeN     = int_type;
        vectorN   = vector;
        idN       = irq_id;
        bN        = b_flag;
        rstHN     = 1'b0;
        nmiHN     = 1'b0;
        irqHN     = 1'b0;
        nmiAccept = 1'b0;
        if (rst_req) begin
            // Reset preempts from any state; an aborted sequence never reports completion.
            stateN  = RSTSEQ;
            takeN   = 1'b1;
            typeN   = 2'd1;
            vectorN = RST_VEC;
            idN     = '0;
            bN      = 1'b0;
        end else begin
            case (state)
                RSTSEQ, ACTIVE: begin
                    if (done) begin
                        stateN = IDLE;
                        rstHN  = state == RSTSEQ;
                        nmiHN  = state == ACTIVE && int_type == 2'd2;
                        irqHN  = state == ACTIVE && int_type == 2'd3;
                        {takeN, typeN, vectorN, idN, bN} = '0;
                    end
                end
                default: begin
                    if (boundary && (nmiPend || |irqReq || brk_op)) begin
                        stateN    = ACTIVE;
                        takeN     = 1'b1;
                        nmiAccept = nmiPend;
                        typeN     = nmiPend ? 2'd2 : 2'd3;
                        vectorN   = nmiPend ? NMI_VEC : IRQ_VEC;
                        idN       = (!nmiPend && |irqReq) ? irqSel : '0;
                        bN        = !nmiPend && !(|irqReq);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge phi1) begin
        if (rst) begin
            state       <= RSTSEQ;
            take        <= 1'b1;
            int_type    <= 2'd1;
            vector      <= RST_VEC;
            irq_id      <= '0;
            b_flag      <= 1'b0;
            rst_handled <= 1'b0;
            nmi_handled <= 1'b0;
            irq_handled <= 1'b0;
            nmiPrev     <= 1'b1;
            nmiPend     <= 1'b0;
        end else begin
            state       <= stateN;
            take        <= takeN;
            int_type    <= typeN;
            vector      <= vectorN;
            irq_id      <= idN;
            b_flag      <= bN;
            rst_handled <= rstHN;
            nmi_handled <= nmiHN;
            irq_handled <= irqHN;
            nmiPrev     <= nmi_n;
            nmiPend     <= (nmiPrev & ~nmi_n) | (nmiPend & ~nmiAccept);
        end
    end
endmodule
